// File: rtl/ct_ifu_sram128x16_ctrl_if.sv
// IFU-side request/response and SRAM macro port bundle for ct_ifu_sram128x16_ctrl.
// master = IFU logic plus SRAM macro; slave = the controller.
interface ct_ifu_sram128x16_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_ready;
    logic                  rd_vld;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] wr_mask;
    logic                  wr_ready;
    logic                  inv_req;
    logic                  ctrl_busy;
    logic [ADDR_WIDTH-1:0] sram_a;
    logic                  sram_cen;
    logic                  sram_gwen;
    logic [DATA_WIDTH-1:0] sram_d;
    logic [DATA_WIDTH-1:0] sram_wen;
    logic [DATA_WIDTH-1:0] sram_q;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_mask, inv_req, sram_q,
        input  rd_ready, rd_vld, rd_data, wr_ready, ctrl_busy,
               sram_a, sram_cen, sram_gwen, sram_d, sram_wen
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_mask, inv_req, sram_q,
        output rd_ready, rd_vld, rd_data, wr_ready, ctrl_busy,
               sram_a, sram_cen, sram_gwen, sram_d, sram_wen
    );
endinterface

// File: rtl/ct_ifu_sram128x16_ctrl.sv
// Merges IFU reads and a one-entry masked write buffer onto the single SRAM port.
// Define CT_IFU_SRAM128_INIT_EN to run the zeroing sweep straight out of reset.
module ct_ifu_sram128x16_ctrl #(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                    forever_cpuclk,
    input  logic                    cpurst_b,
    ct_ifu_sram128x16_ctrl_if.slave bus
);

    typedef enum logic {
        INIT,
        IDLE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] sweep_cnt_q, sweep_cnt_d;
    logic [1:0]            starve_q, starve_d;

    logic                  buf_vld_q, buf_vld_d;
    logic [ADDR_WIDTH-1:0] buf_addr_q, buf_addr_d;
    logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
    logic [DATA_WIDTH-1:0] buf_mask_q, buf_mask_d;

    logic                  rd_vld_q, rd_vld_d;
    logic [DATA_WIDTH-1:0] snap_data_q, snap_data_d;
    logic [DATA_WIDTH-1:0] snap_mask_q, snap_mask_d;
    logic [DATA_WIDTH-1:0] rd_hold_q, rd_hold_d;

    logic                  busy;
    logic                  rd_ready;
    logic                  wr_ready;
    logic                  rd_fire;
    logic                  wr_fire;
    logic                  drain;
    logic [DATA_WIDTH-1:0] rd_merged;

    // Port arbitration: read first, then buffer drain; a saturated starvation
    // counter withholds rd_ready for one cycle so the drain wins.
    always_comb begin
        busy      = (state_q == INIT);
        rd_ready  = (state_q == IDLE) && (starve_q != 2'd3);
        rd_fire   = bus.rd_req & rd_ready;
        drain     = (state_q == IDLE) & buf_vld_q & ~rd_fire;
        wr_ready  = ~busy & (~buf_vld_q | drain);
        wr_fire   = bus.wr_req & wr_ready;
        rd_merged = (bus.sram_q & ~snap_mask_q) | (snap_data_q & snap_mask_q);
    end

    always_comb begin
        bus.sram_a    = '0;
        bus.sram_cen  = 1'b1;
        bus.sram_gwen = 1'b1;
        bus.sram_d    = '0;
        bus.sram_wen  = '1;
        if (state_q == INIT) begin
            bus.sram_a    = sweep_cnt_q;
            bus.sram_cen  = 1'b0;
            bus.sram_gwen = 1'b0;
            bus.sram_wen  = '0;
        end else if (rd_fire) begin
            bus.sram_a   = bus.rd_addr;
            bus.sram_cen = 1'b0;
        end else if (drain) begin
            bus.sram_a    = buf_addr_q;
            bus.sram_cen  = 1'b0;
            bus.sram_gwen = 1'b0;
            bus.sram_d    = buf_data_q;
            bus.sram_wen  = ~buf_mask_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        if (bus.inv_req) begin
            state_d     = INIT;
            sweep_cnt_d = '0;
        end else if (state_q == INIT) begin
            sweep_cnt_d = sweep_cnt_q + 1'b1;
            if (sweep_cnt_q == '1) begin
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        buf_vld_d  = buf_vld_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        buf_mask_d = buf_mask_q;
        if (drain) begin
            buf_vld_d = 1'b0;
        end
        if (wr_fire) begin
            buf_vld_d  = 1'b1;
            buf_addr_d = bus.wr_addr;
            buf_data_d = bus.wr_data;
            buf_mask_d = bus.wr_mask;
        end
        if (bus.inv_req) begin
            buf_vld_d = 1'b0;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (bus.inv_req || drain || !buf_vld_q) begin
            starve_d = 2'd0;
        end else if (rd_fire) begin
            starve_d = starve_q + 2'd1;
        end
    end

    // Snapshot uses the buffer as it stands before this cycle's write is taken,
    // so a same-cycle read and write to one address returns the old contents.
    always_comb begin
        rd_vld_d    = rd_fire;
        snap_data_d = snap_data_q;
        snap_mask_d = snap_mask_q;
        rd_hold_d   = rd_vld_q ? rd_merged : rd_hold_q;
        if (rd_fire) begin
            snap_data_d = buf_data_q;
            snap_mask_d = (buf_vld_q && (buf_addr_q == bus.rd_addr)) ? buf_mask_q : '0;
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
`ifdef CT_IFU_SRAM128_INIT_EN
            state_q <= INIT;
`else
            state_q <= IDLE;
`endif
            sweep_cnt_q <= '0;
            starve_q    <= 2'd0;
            buf_vld_q   <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            buf_mask_q  <= '0;
            rd_vld_q    <= 1'b0;
            snap_data_q <= '0;
            snap_mask_q <= '0;
            rd_hold_q   <= '0;
        end else begin
            state_q     <= state_d;
            sweep_cnt_q <= sweep_cnt_d;
            starve_q    <= starve_d;
            buf_vld_q   <= buf_vld_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            buf_mask_q  <= buf_mask_d;
            rd_vld_q    <= rd_vld_d;
            snap_data_q <= snap_data_d;
            snap_mask_q <= snap_mask_d;
            rd_hold_q   <= rd_hold_d;
        end
    end

    assign bus.rd_ready  = rd_ready;
    assign bus.wr_ready  = wr_ready;
    assign bus.ctrl_busy = busy;
    assign bus.rd_vld    = rd_vld_q;
    assign bus.rd_data   = rd_vld_q ? rd_merged : rd_hold_q;

endmodule
